pca24s08a_write_scheduler: RTL and testbench
============================================

Name: pca24s08a_write_scheduler

Overview:
- Sits between two independent byte-write requesters and the single PCA24S08A byte-write engine on the shared I2C bus.
- Arbitrates round-robin, latches the winning request and issues the start pulse to the engine.
- Waits for engine completion, then enforces the EEPROM internal write-cycle time (tWR) before the next transfer.
- Reports per-requester completion, with an error flag on engine timeout.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- TWR_US, 5000, EEPROM write-cycle hold-off in microseconds. TWR_CYCLES = (CLK_FREQ/1_000_000)*TWR_US, which must be ≥1.
- TIMEOUT_CYCLES, 10_000, maximum clk cycles allowed between bw_start and bw_done.

Ports:
- clk in 1: system clock; all logic on rising edge.
- rst in 1: synchronous reset, active-high.
- req0_valid in 1: requester 0 has a write pending.
- req0_ready out 1: request 0 accepted this cycle (valid&&ready = transfer).
- req0_addr in 10: {block[9:7], page[6:4], byte[3:0]}.
- req0_data in 8: data byte.
- req0_done out 1: one-cycle pulse when requester 0 write is finished.
- req1_valid, req1_ready, req1_addr, req1_data, req1_done: same as requester 0.
- resp_err out 1: valid with a done pulse; 1 means the engine timed out.
- bw_start out 1: one-cycle start pulse to the byte-write engine.
- bw_block out 3, bw_page out 3, bw_byte out 4, bw_data out 8: held stable from bw_start until the scheduler returns to IDLE.
- bw_done in 1: engine completion; pulse or level, acted on at its rising edge.
- busy out 1: high whenever state != IDLE.

Behaviour:
- Reset (synchronous, sampled at clk edge; wins over everything, including mid-transfer):
  - state=IDLE; bw_start, req*_done, resp_err = 0.
  - bw_* registers = 0; bw_done edge register = 0; counters = 0.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE, ISSUE, WAIT_DONE, TWR_WAIT.
- IDLE:
  - req0_ready and req1_ready are combinational from state, last_grant and valids; at most one is high, and only in IDLE.
  - One valid: that requester is granted. Both valid: the requester != last_grant is granted.
  - On transfer: latch addr/data into bw_*, record grant id, go to ISSUE.
- ISSUE: bw_start=1 for exactly this cycle; load timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - Rising edge of bw_done (bw_done & ~bw_done_q): load tWR counter with TWR_CYCLES-1, go to TWR_WAIT.
  - Timeout counter expires first (TIMEOUT_CYCLES cycles after bw_start): go to IDLE; granted req*_done=1 and resp_err=1 in that first IDLE cycle. tWR is skipped.
- TWR_WAIT: decrement each cycle; at 0, go to IDLE with granted req*_done=1, resp_err=0 in the first IDLE cycle. Duration is exactly TWR_CYCLES cycles.
- On leaving to IDLE: last_grant = grant id.
- Latency: transfer at cycle T → bw_start at T+1. Done pulse arrives TWR_CYCLES+1 cycles after the cycle bw_done rises.
- Back-to-back: a new transfer is accepted in the same cycle as the previous done pulse; there are no idle bubbles beyond that.
- Boundary cases:
  - bw_done rising outside WAIT_DONE is ignored. A bw_done already high at bw_start does not count; the engine must produce a new rising edge.
  - A bw_done edge and timeout expiry in the same cycle: bw_done wins (normal completion).
  - Requester inputs are don't-care outside the accept cycle.
  - A requester deasserting valid before ready is legal; no transfer occurs.
- Widths: counter width = $clog2(max(TWR_CYCLES, TIMEOUT_CYCLES)+1). The tWR and timeout counters may share one register.

Test Plan (CLK_FREQ=50_000_000, TWR_US=1 → TWR_CYCLES=50, TIMEOUT_CYCLES=200; engine model raises bw_done 30 cycles after bw_start):
1. Single request: req0 addr=10'b110_010_1111, data=8'hC9.
   - Expected: req0_ready for 1 cycle, bw_start next cycle with bw_block=6, bw_page=2, bw_byte=15, bw_data=C9.
   - Expected: req0_done with resp_err=0 exactly 51 cycles after bw_done rises; busy low afterwards.
2. Simultaneous valid from reset: grants req0 then req1. Keep both valid: grants alternate 0,1,0,1 over four writes; each done goes only to the granted requester.
3. Back-to-back: req1 valid continuously. A new transfer occurs in each done cycle; consecutive bw_start pulses are spaced 30+50+2 cycles apart.
4. Timeout: engine never asserts bw_done.
   - Expected: req0_done=1 and resp_err=1 exactly 200 cycles after bw_start; no tWR wait.
   - Expected: the next request is accepted in that cycle.
5. Reset mid-operation: assert rst during TWR_WAIT.
   - Expected: next cycle IDLE, busy=0, no done pulse, bw_* = 0.
   - Expected: tie after reset grants req0.
6. Spurious bw_done: in IDLE, and stuck high at bw_start → ignored. The write completes only on a fresh rising edge, or times out at 200 cycles.

Source files
------------

// File: rtl/pca24s08a_write_scheduler.sv
// pca24s08a_write_scheduler
// Arbitrates two byte-write requesters onto one PCA24S08A byte-write engine.
// Each granted write is issued with a start pulse. The scheduler then waits
// for the engine to finish and holds off for the EEPROM write-cycle time
// before the next transfer can start.
// The tWR and timeout counts share one down-counter, because the two phases
// never overlap.
// TIMEOUT_CYCLES must be at least 2: one cycle is spent in ISSUE and the
// rest in WAIT_DONE.
module pca24s08a_write_scheduler #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int TWR_US         = 5000,
  parameter int TIMEOUT_CYCLES = 10_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [9:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_done,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [9:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_done,
  output logic       resp_err,
  output logic       bw_start,
  output logic [2:0] bw_block,
  output logic [2:0] bw_page,
  output logic [3:0] bw_byte,
  output logic [7:0] bw_data,
  input  logic       bw_done,
  output logic       busy
);

  localparam int TWR_CYCLES = (CLK_FREQ / 1_000_000) * TWR_US;
  localparam int MAX_CYCLES = (TWR_CYCLES > TIMEOUT_CYCLES) ? TWR_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // tWR_WAIT spans TWR_CYCLES cycles (count TWR_CYCLES-1 down to 0).
  // The timeout load leaves room for the ISSUE cycle, so expiry lands exactly
  // TIMEOUT_CYCLES cycles after bw_start.
  localparam logic [CNT_W-1:0] TWR_LOAD = CNT_W'(TWR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    TWR_WAIT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             bw_done_q;
  logic             done_rise;
  logic             grant;
  logic             last_grant;
  logic             accept;
  logic             finish;
  logic             finish_err;
  logic [9:0]       sel_addr;
  logic [7:0]       sel_data;

  // Round-robin grant: a lone valid wins, a tie goes to the requester that was not served last
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
      req0_ready = req0_valid && (!req1_valid || last_grant);
      req1_ready = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign accept    = req0_ready || req1_ready;
  assign sel_addr  = req1_ready ? req1_addr : req0_addr;
  assign sel_data  = req1_ready ? req1_data : req0_data;
  assign done_rise = bw_done && !bw_done_q;
  assign bw_start  = (state == ISSUE);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter logic; an engine edge takes priority over timeout expiry
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    finish     = 1'b0;
    finish_err = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = TO_LOAD;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise) begin
          cnt_next   = TWR_LOAD;
          state_next = TWR_WAIT;
        end else if (cnt == '0) begin
          state_next = IDLE;
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      TWR_WAIT: begin
        if (cnt == '0) begin
          state_next = IDLE;
          finish     = 1'b1;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the granted request, track bw_done history and emit done/err pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bw_block   <= '0;
      bw_page    <= '0;
      bw_byte    <= '0;
      bw_data    <= '0;
      bw_done_q  <= 1'b0;
      cnt        <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      bw_done_q <= bw_done;
      cnt       <= cnt_next;
      if (accept) begin
        grant    <= req1_ready;
        bw_block <= sel_addr[9:7];
        bw_page  <= sel_addr[6:4];
        bw_byte  <= sel_addr[3:0];
        bw_data  <= sel_data;
      end
      if (finish) begin
        last_grant <= grant;
      end
      req0_done <= finish && !grant;
      req1_done <= finish && grant;
      resp_err  <= finish && finish_err;
    end
  end

endmodule

// File: tb/tb_pca24s08a_write_scheduler.sv
// tb_pca24s08a_write_scheduler
// Randomized bench for the write scheduler.
// A transaction-level model predicts, from arithmetic on cycle numbers, when
// each write is granted, started and completed. The engine is emulated with
// a per-transaction bw_done plan: a normal pulse, a late edge at expiry, no
// response, or bw_done stuck high. Spurious bw_done pulses are also driven,
// and resets are injected during tWR.
module tb_pca24s08a_write_scheduler;

  localparam int CLK_FREQ = 50_000_000;
  localparam int TWR_US   = 1;
  localparam int TIMEOUT  = 200;
  localparam int TWR      = 50;
  localparam int NUM_TXN  = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_done;
  logic [9:0] req0_addr;
  logic [7:0] req0_data;
  logic       req1_valid, req1_ready, req1_done;
  logic [9:0] req1_addr;
  logic [7:0] req1_data;
  logic       resp_err, bw_start, bw_done, busy;
  logic [2:0] bw_block, bw_page;
  logic [3:0] bw_byte;
  logic [7:0] bw_data;

  pca24s08a_write_scheduler #(
    .CLK_FREQ      (CLK_FREQ),
    .TWR_US        (TWR_US),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_done (req0_done),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_done (req1_done),
    .resp_err  (resp_err),
    .bw_start  (bw_start),
    .bw_block  (bw_block),
    .bw_page   (bw_page),
    .bw_byte   (bw_byte),
    .bw_data   (bw_data),
    .bw_done   (bw_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int txn_count;

  bit         m_busy, m_grant, m_last;
  int         m_start, m_done;
  logic [9:0] m_addr;
  logic [7:0] m_data;
  int         d_cyc;
  bit         d_grant, d_err;
  bit         exp_r0, exp_r1;
  int         p_s, p_h, p_l, p_w;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, actual, expected);
    end
  endtask

  task automatic resetModel();
    m_busy  = 1'b0;
    m_grant = 1'b0;
    m_last  = 1'b1;
    m_addr  = '0;
    m_data  = '0;
    d_cyc   = -1;
  endtask

  task automatic choosePlan(input bit directed);
    int mode;
    p_s = cyc + 1;
    p_w = $urandom_range(1, 4);
    p_h = 0;
    if (directed) begin
      p_l = 30;
    end else begin
      mode = $urandom_range(0, 5);
      case (mode)
        0, 1:    p_l = 30;
        2:       p_l = $urandom_range(1, TIMEOUT - 1);
        3:       p_l = TIMEOUT - 1;
        4:       p_l = 0;
        default: begin p_l = 0; p_h = 250; end
      endcase
      if (mode != 5 && $urandom_range(0, 2) == 0) p_h = $urandom_range(1, 5);
      if (p_l > 0 && p_l <= p_h) p_h = 0;
    end
  endtask

  task automatic applyStimulus(input bit force_rst, input bit quiet);
    rst = force_rst;
    if (!quiet && !force_rst && txn_count >= 17 && m_busy && p_l > 0 && cyc > p_s + p_l
        && $urandom_range(0, 149) == 0)
      rst = 1'b1;
    req0_addr = 10'($urandom);
    req0_data = 8'($urandom);
    req1_addr = 10'($urandom);
    req1_data = 8'($urandom);
    if (quiet) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end else if (txn_count == 0) begin
      req0_valid = 1'b1;
      req0_addr  = 10'b110_010_1111;
      req0_data  = 8'hC9;
      req1_valid = 1'b0;
    end else if (txn_count < 9) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
    end else if (txn_count < 17) begin
      req0_valid = 1'b0;
      req1_valid = 1'b1;
    end else begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
    end
    if (m_busy && cyc >= p_s && cyc <= p_s + TIMEOUT - 1)
      bw_done = (cyc < p_s + p_h) || (p_l > 0 && cyc >= p_s + p_l && cyc < p_s + p_l + p_w);
    else
      bw_done = ($urandom_range(0, 3) == 0);
  endtask

  task automatic compareCycle();
    exp_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
    exp_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
    checkOutput("req0_ready", 32'(req0_ready), 32'(exp_r0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(exp_r1));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("bw_start", 32'(bw_start), 32'(m_busy && cyc == m_start));
    checkOutput("bw_fields", 32'({bw_block, bw_page, bw_byte, bw_data}), 32'({m_addr, m_data}));
    checkOutput("req0_done", 32'(req0_done), 32'(cyc == d_cyc && !d_grant));
    checkOutput("req1_done", 32'(req1_done), 32'(cyc == d_cyc && d_grant));
    if (cyc == d_cyc) checkOutput("resp_err", 32'(resp_err), 32'(d_err));
  endtask

  task automatic updateModel();
    if (rst) begin
      resetModel();
    end else if (exp_r0 || exp_r1) begin
      m_busy  = 1'b1;
      m_grant = exp_r1;
      m_addr  = exp_r1 ? req1_addr : req0_addr;
      m_data  = exp_r1 ? req1_data : req0_data;
      choosePlan(txn_count == 0);
      m_start = p_s;
      if (p_l >= 1 && p_l <= TIMEOUT - 1) begin
        m_done = p_s + p_l + TWR + 1;
        d_err  = 1'b0;
      end else begin
        m_done = p_s + TIMEOUT;
        d_err  = 1'b1;
      end
      d_cyc   = m_done;
      d_grant = m_grant;
      txn_count++;
    end else if (m_busy && cyc + 1 == m_done) begin
      m_busy = 1'b0;
      m_last = m_grant;
    end
    cyc++;
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = '0;
    req1_addr  = '0;
    req1_data  = '0;
    bw_done    = 1'b0;
    cyc        = 0;
    txn_count  = 0;
    p_s = 0; p_h = 0; p_l = 0; p_w = 0;
    m_start = -1; m_done = -1;
    d_grant = 1'b0; d_err = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    while (txn_count < NUM_TXN && cyc < 30000) begin
      applyStimulus(cyc < 2, 1'b0);
      @(negedge clk);
      compareCycle();
      @(posedge clk);
      updateModel();
      #1;
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      compareCycle();
      @(posedge clk);
      updateModel();
      #1;
    end
    checkOutput("txn_budget", 32'(txn_count >= NUM_TXN), 32'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
